// File: rtl/pal_cfg_fabric_if.sv
// rtl/pal_cfg_fabric_if.sv - serial configuration port bundle for pal_cfg_fabric
//
// Purpose: groups the loader handshake between the config source (master)
//          and the PAL fabric (slave).
// Signals:
//   CFG_START  master->slave  pulse: begin or restart a config load
//   CFG_VALID  master->slave  CFG_DATA holds a valid bit this cycle
//   CFG_DATA   master->slave  serial config bit
//   CFG_APPLY  master->slave  pulse: commit shadow chain to active plane
//   CFG_FULL   slave->master  shadow chain holds a complete new image
//   CFG_DONE   slave->master  one-cycle pulse after a commit
//   CFG_ERR    slave->master  sticky protocol-error flag
interface pal_cfg_fabric_if;
  logic CFG_START;
  logic CFG_VALID;
  logic CFG_DATA;
  logic CFG_APPLY;
  logic CFG_FULL;
  logic CFG_DONE;
  logic CFG_ERR;

  modport master (
    output CFG_START, CFG_VALID, CFG_DATA, CFG_APPLY,
    input  CFG_FULL, CFG_DONE, CFG_ERR
  );

  modport slave (
    input  CFG_START, CFG_VALID, CFG_DATA, CFG_APPLY,
    output CFG_FULL, CFG_DONE, CFG_ERR
  );
endinterface

// File: rtl/pal_cfg_fabric.sv
// rtl/pal_cfg_fabric.sv - reconfigurable N-input, P-term, M-output AND/OR fabric
//
// Purpose: PAL-style AND/OR array with per-output polarity. A new image is
//          shifted serially into a shadow chain and committed atomically, so
//          the fabric keeps evaluating the old function during a load.
// Optional: PAL_REG_OUT_EN adds per-output REG select bits and output flops.
// Ports:
//   CLK          clock
//   RES          synchronous active-high reset
//   ENA          global enable; 0 freezes loader and output flops
//   cfg          pal_cfg_fabric_if.slave config handshake
//   INPUT_VARS   N fabric inputs
//   OUTPUT_VALS  M fabric outputs
// Chain layout (from index 0): AND plane (term p at p*2N, bit i = x_i,
//   bit N+i = ~x_i), OR plane at 2NP (output m at +m*P), INV at 2NP+MP,
//   REG (optional) after INV. First bit shifted in ends up at index L-1.
module pal_cfg_fabric #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int P = 8
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             ENA,
  pal_cfg_fabric_if.slave  cfg,
  input  logic [N-1:0]     INPUT_VARS,
  output logic [M-1:0]     OUTPUT_VALS
);

  localparam int A = 2 * N * P;
  localparam int B = A + M * P;
`ifdef PAL_REG_OUT_EN
  localparam int L = B + 2 * M;
`else
  localparam int L = B + M;
`endif
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [L-1:0]  shadow_q, shadow_d;
  logic [L-1:0]  active_q, active_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  // Loader: START has priority over everything else in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    done_d   = 1'b0;
    if (ENA) begin
      if (cfg.CFG_START) begin
        state_d = S_LOAD;
        cnt_d   = '0;
        err_d   = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cfg.CFG_APPLY) err_d = 1'b1;
          end
          S_LOAD: begin
            if (cfg.CFG_APPLY) err_d = 1'b1;
            if (cfg.CFG_VALID) begin
              shadow_d = {shadow_q[L-2:0], cfg.CFG_DATA};
              cnt_d    = cnt_q + 1'b1;
              if (cnt_q == LAST) state_d = S_FULL;
            end
          end
          S_FULL: begin
            // Overrun: bit is dropped, shadow image stays intact.
            if (cfg.CFG_VALID) err_d = 1'b1;
            if (cfg.CFG_APPLY) begin
              active_d = shadow_q;
              state_d  = S_IDLE;
              done_d   = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign cfg.CFG_FULL = (state_q == S_FULL);
  assign cfg.CFG_DONE = done_q;
  assign cfg.CFG_ERR  = err_q;

  // Fabric evaluation from the active plane only.
  logic [2*N-1:0] lits;
  logic [P-1:0]   term;
  logic [M-1:0]   comb_out;

  assign lits = {~INPUT_VARS, INPUT_VARS};

  for (genvar gp = 0; gp < P; gp++) begin : g_term
    logic [2*N-1:0] sel;
    assign sel = active_q[gp*2*N +: 2*N];
    // Unselected literals are forced true; an empty term is forced to 0.
    assign term[gp] = (|sel) & (&(lits | ~sel));
  end

  for (genvar gm = 0; gm < M; gm++) begin : g_out
    assign comb_out[gm] = (|(active_q[A+gm*P +: P] & term)) ^ active_q[B+gm];
  end

`ifdef PAL_REG_OUT_EN
  logic [M-1:0] out_q;
  logic [M-1:0] reg_sel;

  assign reg_sel = active_q[B+M +: M];

  always_ff @(posedge CLK) begin
    if (RES) begin
      out_q <= '0;
    end else if (ENA) begin
      out_q <= comb_out;
    end
  end

  assign OUTPUT_VALS = (reg_sel & out_q) | (~reg_sel & comb_out);
`else
  assign OUTPUT_VALS = comb_out;
`endif

endmodule
